// File: rtl/ws2811_pkg.sv
// Shared types and helpers for the ws2811 LED driver and its frame controller.
// Latency: n/a (types, constants and a combinational scaling helper only).
// Backpressure: n/a.
package ws2811_pkg;

  localparam int COLOR_WIDTH     = 8;
  localparam int FRAME_CNT_WIDTH = 16;
  localparam int PROD_WIDTH      = 2 * COLOR_WIDTH;

  // One pixel as the driver shifts it out: red, green, blue.
  typedef struct packed {
    logic [COLOR_WIDTH-1:0] r;
    logic [COLOR_WIDTH-1:0] g;
    logic [COLOR_WIDTH-1:0] b;
  } pixel_t;

  // (c * (b + 1)) >> 8. The +1 makes b = 255 an exact identity, and the
  // full-scale product 255 * 256 still fits in PROD_WIDTH bits.
  function automatic logic [COLOR_WIDTH-1:0] scale_chan(
    input logic [COLOR_WIDTH-1:0] c,
    input logic [COLOR_WIDTH-1:0] b
  );
    logic [PROD_WIDTH-1:0] prod;
    prod = {{COLOR_WIDTH{1'b0}}, c} * ({{COLOR_WIDTH{1'b0}}, b} + PROD_WIDTH'(1));
    return prod[PROD_WIDTH-1:COLOR_WIDTH];
  endfunction

endpackage

// File: rtl/ws2811_color_scale.sv
// Registered 3-channel brightness scaler: out = (c * (bright + 1)) >> 8.
// Latency: 1 cycle, input pixel to registered output.
// Backpressure: none, it accepts a new pixel every cycle.
//
// Ports:
//   clk, reset         : clock and synchronous active-low reset (outputs clear to 0)
//   r_i, g_i, b_i      : unscaled pixel color
//   bright_i           : brightness factor, 255 is identity
//   red_o/green_o/blue_o : scaled, registered color
module ws2811_color_scale
  import ws2811_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic [COLOR_WIDTH-1:0] r_i,
  input  logic [COLOR_WIDTH-1:0] g_i,
  input  logic [COLOR_WIDTH-1:0] b_i,
  input  logic [COLOR_WIDTH-1:0] bright_i,
  output logic [COLOR_WIDTH-1:0] red_o,
  output logic [COLOR_WIDTH-1:0] green_o,
  output logic [COLOR_WIDTH-1:0] blue_o
);

  pixel_t out_q, out_d;

  always_comb begin
    out_d   = '0;
    out_d.r = scale_chan(r_i, bright_i);
    out_d.g = scale_chan(g_i, bright_i);
    out_d.b = scale_chan(b_i, bright_i);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign red_o   = out_q.r;
  assign green_o = out_q.g;
  assign blue_o  = out_q.b;

endmodule

// File: rtl/ws2811_frame_ctrl.sv
// Double-buffered pixel store for the ws2811 driver; swaps banks only at a frame boundary.
// Latency: 2 cycles from driver address to scaled color; wr_err/swap_done are 1-cycle registered pulses.
// Backpressure: wr_ready and commit_ready both drop while a committed swap waits for the next boundary.
//
// Ports:
//   clk, reset                 : clock and synchronous active-low reset
//   address                    : pixel index requested by the driver
//   red_out/green_out/blue_out : front-bank color scaled by the latched brightness
//   wr_valid/wr_ready          : host write handshake; wr_addr + wr_red/green/blue go to the back bank
//   wr_err                     : pulse after an accepted write whose address was out of range
//   commit/commit_ready        : request a bank swap at the next frame boundary
//   brightness                 : global brightness, latched once per frame
//   swap_done                  : pulse after the banks swapped
//   frame_count                : number of frame boundaries seen, wraps
module ws2811_frame_ctrl
  import ws2811_pkg::*;
#(
  parameter int NUM_LEDS   = 8,
  parameter int ADDR_WIDTH = $clog2(NUM_LEDS)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [ADDR_WIDTH-1:0]      address,
  output logic [COLOR_WIDTH-1:0]     red_out,
  output logic [COLOR_WIDTH-1:0]     green_out,
  output logic [COLOR_WIDTH-1:0]     blue_out,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [ADDR_WIDTH-1:0]      wr_addr,
  input  logic [COLOR_WIDTH-1:0]     wr_red,
  input  logic [COLOR_WIDTH-1:0]     wr_green,
  input  logic [COLOR_WIDTH-1:0]     wr_blue,
  output logic                       wr_err,
  input  logic                       commit,
  output logic                       commit_ready,
  input  logic [COLOR_WIDTH-1:0]     brightness,
  output logic                       swap_done,
  output logic [FRAME_CNT_WIDTH-1:0] frame_count
);

  localparam int IDX_W = $clog2(NUM_LEDS);
  // Range limits widened by one bit so NUM_LEDS itself is representable.
  localparam logic [ADDR_WIDTH:0] NUM_W  = (ADDR_WIDTH + 1)'(NUM_LEDS);
  localparam logic [ADDR_WIDTH:0] LAST_W = (ADDR_WIDTH + 1)'(NUM_LEDS - 1);

  pixel_t bank0_q [NUM_LEDS];
  pixel_t bank1_q [NUM_LEDS];

  logic [ADDR_WIDTH-1:0]      addr_q;
  logic                       front_sel_q, front_sel_d;
  logic                       swap_pending_q, swap_pending_d;
  logic [COLOR_WIDTH-1:0]     bright_q, bright_d;
  logic [FRAME_CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
  logic                       wr_err_q, wr_err_d;
  logic                       swap_done_q, swap_done_d;

  logic   boundary;
  logic   wr_acc;
  logic   cmt_acc;
  logic   wr_in_range;
  logic   rd_in_range;
  pixel_t wr_pix;
  pixel_t rd_pix;

  assign wr_ready     = !swap_pending_q;
  assign commit_ready = !swap_pending_q;
  assign wr_acc       = wr_valid && wr_ready;
  assign cmt_acc      = commit && commit_ready;
  assign wr_in_range  = ({1'b0, wr_addr} < NUM_W);
  assign rd_in_range  = ({1'b0, addr_q} < NUM_W);

  // The driver wraps from the last pixel back to 0 exactly once per frame.
  assign boundary = ({1'b0, addr_q} == LAST_W) && (address == '0);

  assign wr_pix = {wr_red, wr_green, wr_blue};

  always_comb begin
    front_sel_d    = front_sel_q;
    swap_pending_d = swap_pending_q;
    bright_d       = bright_q;
    frame_cnt_d    = frame_cnt_q;
    swap_done_d    = 1'b0;
    wr_err_d       = wr_acc && !wr_in_range;
    if (boundary) begin
      frame_cnt_d = frame_cnt_q + FRAME_CNT_WIDTH'(1);
      bright_d    = brightness;
      // Only a commit that was already pending swaps here; a commit taken
      // in this same cycle is left pending for the following boundary.
      if (swap_pending_q) begin
        front_sel_d    = !front_sel_q;
        swap_pending_d = 1'b0;
        swap_done_d    = 1'b1;
      end
    end
    // commit_ready is low while pending, so this never collides with the clear above.
    if (cmt_acc) begin
      swap_pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      addr_q         <= '0;
      front_sel_q    <= 1'b0;
      swap_pending_q <= 1'b0;
      bright_q       <= '1;
      frame_cnt_q    <= '0;
      wr_err_q       <= 1'b0;
      swap_done_q    <= 1'b0;
    end else begin
      addr_q         <= address;
      front_sel_q    <= front_sel_d;
      swap_pending_q <= swap_pending_d;
      bright_q       <= bright_d;
      frame_cnt_q    <= frame_cnt_d;
      wr_err_q       <= wr_err_d;
      swap_done_q    <= swap_done_d;
    end
  end

  // Banks are never cleared; writes always land in the bank the driver is not reading.
  always_ff @(posedge clk) begin
    if (reset && wr_acc && wr_in_range) begin
      if (front_sel_q) begin
        bank0_q[wr_addr[IDX_W-1:0]] <= wr_pix;
      end else begin
        bank1_q[wr_addr[IDX_W-1:0]] <= wr_pix;
      end
    end
  end

  // Read uses the already-updated front_sel, so address 0 after a swap sees the new frame.
  always_comb begin
    rd_pix = '0;
    if (rd_in_range) begin
      rd_pix = front_sel_q ? bank1_q[addr_q[IDX_W-1:0]] : bank0_q[addr_q[IDX_W-1:0]];
    end
  end

  ws2811_color_scale u_scale (
    .clk      (clk),
    .reset    (reset),
    .r_i      (rd_pix.r),
    .g_i      (rd_pix.g),
    .b_i      (rd_pix.b),
    .bright_i (bright_q),
    .red_o    (red_out),
    .green_o  (green_out),
    .blue_o   (blue_out)
  );

  assign wr_err      = wr_err_q;
  assign swap_done   = swap_done_q;
  assign frame_count = frame_cnt_q;

endmodule

// File: tb/tb_ws2811_frame_ctrl.sv
// Self-checking bench for ws2811_frame_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a frame-level reference model of the two pixel banks.
// Runs with NUM_LEDS = 8 and a 4-bit address so out-of-range indices can be driven.
module tb_ws2811_frame_ctrl;

  localparam int N  = 8;
  localparam int AW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [AW-1:0] address;
  logic [7:0]    red_out, green_out, blue_out;
  logic          wr_valid, wr_ready;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_red, wr_green, wr_blue;
  logic          wr_err;
  logic          commit, commit_ready;
  logic [7:0]    brightness;
  logic          swap_done;
  logic [15:0]   frame_count;

  ws2811_frame_ctrl #(.NUM_LEDS(N), .ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .address      (address),
    .red_out      (red_out),
    .green_out    (green_out),
    .blue_out     (blue_out),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_addr      (wr_addr),
    .wr_red       (wr_red),
    .wr_green     (wr_green),
    .wr_blue      (wr_blue),
    .wr_err       (wr_err),
    .commit       (commit),
    .commit_ready (commit_ready),
    .brightness   (brightness),
    .swap_done    (swap_done),
    .frame_count  (frame_count)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [23:0] m_bank  [2][N];
  bit          m_known [2][N];
  bit          m_front = 0;
  bit          m_pend  = 0;
  int          m_bright = 255;
  int          m_frames = 0;
  int          m_prev_addr = 0;
  logic [23:0] m_exp_pix = '0;   // color expected on the outputs after the next edge
  bit          m_exp_known = 0;

  function automatic logic [23:0] dim(input logic [23:0] p, input int b);
    int r, g, bl;
    r  = (int'(p[23:16]) * (b + 1)) / 256;
    g  = (int'(p[15:8])  * (b + 1)) / 256;
    bl = (int'(p[7:0])   * (b + 1)) / 256;
    return {8'(r), 8'(g), 8'(bl)};
  endfunction

  // Called right after a rising edge: applies the cycle that just ended to the
  // model, then compares the DUT outputs a little later.
  task automatic step();
    logic [23:0] exp_out;
    bit          exp_out_known;
    bit          exp_err;
    bit          exp_done;
    exp_out       = m_exp_pix;
    exp_out_known = m_exp_known;
    exp_err       = 0;
    exp_done      = 0;
    if (!reset) begin
      m_front = 0; m_pend = 0; m_bright = 255; m_frames = 0; m_prev_addr = 0;
      exp_out = '0; exp_out_known = 1;
    end else begin
      bit bnd, wacc, cacc;
      int back;
      bnd  = (m_prev_addr == N - 1) && (int'(address) == 0);
      wacc = wr_valid && !m_pend;
      cacc = commit && !m_pend;
      back = m_front ? 0 : 1;
      if (wacc) begin
        if (int'(wr_addr) < N) begin
          m_bank[back][int'(wr_addr)]  = {wr_red, wr_green, wr_blue};
          m_known[back][int'(wr_addr)] = 1;
        end else begin
          exp_err = 1;
        end
      end
      if (bnd) begin
        m_frames = (m_frames + 1) % 65536;
        m_bright = int'(brightness);
        if (m_pend) begin
          m_front  = !m_front;
          m_pend   = 0;
          exp_done = 1;
        end
      end
      if (cacc) m_pend = 1;
      m_prev_addr = int'(address);
    end
    if (m_prev_addr >= N) begin
      m_exp_pix = '0; m_exp_known = 1;
    end else begin
      m_exp_pix   = dim(m_bank[m_front][m_prev_addr], m_bright);
      m_exp_known = m_known[m_front][m_prev_addr];
    end
    #1;
    check_val("wr_ready", 32'(wr_ready), 32'(!m_pend));
    check_val("commit_ready", 32'(commit_ready), 32'(!m_pend));
    check_val("wr_err", 32'(wr_err), 32'(exp_err));
    check_val("swap_done", 32'(swap_done), 32'(exp_done));
    check_val("frame_count", 32'(frame_count), 32'(m_frames));
    if (exp_out_known) check_val("pixel", 32'({red_out, green_out, blue_out}), 32'(exp_out));
  endtask

  // ---------------- stimulus helpers ----------------
  int seq_addr = 0;
  int hold_left = 0;
  bit drv_rand_oor = 0;

  task automatic tick();
    @(posedge clk);
    step();
    @(negedge clk);
  endtask

  // Driver-like address sweep: each index held 1..3 cycles, wrapping 7 -> 0.
  task automatic advance_addr();
    if (hold_left > 0) begin
      hold_left--;
    end else begin
      if (drv_rand_oor && $urandom_range(0, 19) == 0) begin
        address = AW'(N + $urandom_range(0, 7));
      end else begin
        seq_addr = (seq_addr + 1) % N;
        address  = AW'(seq_addr);
      end
      hold_left = $urandom_range(0, 2);
    end
  endtask

  task automatic hold_addr(input int a, input int n);
    address   = AW'(a);
    seq_addr  = a;
    hold_left = 0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic fill_back();
    for (int i = 0; i < N; i++) begin
      wr_valid = 1; wr_addr = AW'(i);
      wr_red = 8'($urandom); wr_green = 8'($urandom); wr_blue = 8'($urandom);
      advance_addr();
      tick();
    end
    wr_valid = 0;
  endtask

  task automatic run_until_swap(input int budget);
    int n;
    n = 0;
    do begin
      advance_addr();
      tick();
      n++;
    end while (!swap_done && n < budget);
    check_val("swap_seen", 32'(swap_done), 32'd1);
  endtask

  task automatic run_until_frame(input int budget);
    int n;
    int start;
    n = 0;
    start = int'(frame_count);
    do begin
      advance_addr();
      tick();
      n++;
    end while (int'(frame_count) == start && n < budget);
    check_val("frame_adv", 32'(frame_count), 32'((start + 1) % 65536));
  endtask

  initial begin
    bit hit;
    reset = 0; address = '0; wr_valid = 0; wr_addr = '0;
    wr_red = '0; wr_green = '0; wr_blue = '0; commit = 0; brightness = 8'hFF;
    @(negedge clk);
    tick(); tick();
    check_val("rst_rgb", 32'({red_out, green_out, blue_out}), 32'd0);
    check_val("rst_frame", 32'(frame_count), 32'd0);
    reset = 1;

    // Make both banks fully defined: fill back, swap, fill the other, swap.
    fill_back();
    commit = 1; advance_addr(); tick(); commit = 0;
    run_until_swap(100);
    fill_back();
    commit = 1; advance_addr(); tick(); commit = 0;
    run_until_swap(100);

    // Write and swap, with the write and commit in the same cycle, then
    // keep a write request up while the swap is pending.
    wr_valid = 1; wr_addr = AW'(3); wr_red = 8'hFF; wr_green = 8'hAA; wr_blue = 8'h00;
    commit = 1; advance_addr(); tick(); commit = 0;
    check_val("pend_wr_rdy", 32'(wr_ready), 32'd0);
    check_val("pend_cm_rdy", 32'(commit_ready), 32'd0);
    wr_addr = AW'(5); wr_red = 8'h12; wr_green = 8'h34; wr_blue = 8'h56;
    run_until_swap(100);
    check_val("swap_wr_rdy", 32'(wr_ready), 32'd1);
    check_val("swap_cm_rdy", 32'(commit_ready), 32'd1);
    wr_valid = 0;
    hold_addr(3, 3);
    check_val("swap_px3", 32'({red_out, green_out, blue_out}), 32'h00FFAA00);

    // Brightness only takes effect at the next boundary.
    brightness = 8'h7F;
    hold_addr(3, 3);
    check_val("bright_mid", 32'({red_out, green_out, blue_out}), 32'h00FFAA00);
    run_until_frame(100);
    hold_addr(3, 3);
    check_val("bright_new", 32'({red_out, green_out, blue_out}), 32'h007F5500);
    brightness = 8'hFF;
    run_until_frame(100);

    // Commit exactly in the boundary cycle waits one more frame.
    wr_valid = 1; wr_addr = AW'(3); wr_red = 8'h01; wr_green = 8'h02; wr_blue = 8'h03;
    advance_addr(); tick(); wr_valid = 0;
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      advance_addr();
      if (m_prev_addr == N - 1 && int'(address) == 0) begin
        commit = 1; tick(); commit = 0; hit = 1;
      end else begin
        tick();
      end
    end
    check_val("bnd_found", 32'(hit), 32'd1);
    check_val("bnd_no_swap", 32'(swap_done), 32'd0);
    check_val("bnd_pending", 32'(commit_ready), 32'd0);
    run_until_swap(100);

    // Out-of-range host write.
    wr_valid = 1; wr_addr = AW'(8); wr_red = 8'h99; wr_green = 8'h99; wr_blue = 8'h99;
    advance_addr(); tick(); wr_valid = 0;
    check_val("oor_err", 32'(wr_err), 32'd1);
    advance_addr(); tick();
    check_val("oor_err_clr", 32'(wr_err), 32'd0);

    // Reset with a swap pending.
    commit = 1; advance_addr(); tick(); commit = 0;
    check_val("rst_pend_set", 32'(commit_ready), 32'd0);
    reset = 0; wr_valid = 1; wr_addr = AW'(2);
    advance_addr(); tick();
    reset = 1; wr_valid = 0;
    check_val("rstm_rgb", 32'({red_out, green_out, blue_out}), 32'd0);
    check_val("rstm_frame", 32'(frame_count), 32'd0);
    check_val("rstm_cm_rdy", 32'(commit_ready), 32'd1);
    for (int i = 0; i < 30; i++) begin advance_addr(); tick(); end

    // Random traffic.
    drv_rand_oor = 1;
    for (int i = 0; i < 3000; i++) begin
      wr_valid = ($urandom_range(0, 1) == 1);
      wr_addr  = AW'($urandom_range(0, 9));
      wr_red   = 8'($urandom); wr_green = 8'($urandom); wr_blue = 8'($urandom);
      commit   = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 49) == 0) brightness = 8'($urandom);
      reset    = ($urandom_range(0, 599) != 0);
      advance_addr();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
